aib_link_bringup_ctrl: RTL and testbench
========================================

Name: aib_link_bringup_ctrl

Overview:
- Bring-up sequencer for the AIB-to-AXI bridge follower.
- After reset it programs the AIB through the Avalon-MM config port from a parameter table, then releases the adapter resets and raises MAC-ready and DCC/DLL lock requests on the active channels.
- It then waits for transfer-enable and RX alignment, and reports link status.
- It retries on timeout and drops the link if readiness is lost.

Parameters:
- NBR_CHNLS, 24, total AIB channels (width of per-channel vectors).
- ACTIVE_CHNLS, 1, channels [ACTIVE_CHNLS-1:0] are sequenced; all others are held 0.
- AVMM_WIDTH, 32, config write data width.
- BYTE_WIDTH, 4, config byte-enable width.
- NUM_CFG, 4, number of config writes in the table; range 1..16.
- CFG_ADDR, 0, packed NUM_CFG*17 bits; entry i is at [17*i +: 17].
- CFG_DATA, 0, packed NUM_CFG*AVMM_WIDTH bits; entry i is at [AVMM_WIDTH*i +: AVMM_WIDTH].
- SETTLE_CYC, 16, cycles between adapter-reset release and lock request.
- TIMEOUT_CYC, 65535, maximum cycles spent in WAIT_XFER.
- MAX_RETRY, 3, retries allowed before FAIL.

Ports:
- clk_wr  in  1  Single clock; the config port runs on this clock.
- rst_wr  in  1  Synchronous, active-high reset.
- start  in  1  One-cycle pulse; starts bring-up from IDLE or FAIL.
- o_cfg_avmm_addr  out  17  Config address.
- o_cfg_avmm_byte_en  out  BYTE_WIDTH  Always all-ones during a write.
- o_cfg_avmm_write  out  1  Config write strobe.
- o_cfg_avmm_wdata  out  AVMM_WIDTH  Config write data.
- i_cfg_avmm_waitreq  in  1  Config port stall.
- ns_adapter_rstn  out  NBR_CHNLS  Adapter reset release, per channel.
- ns_mac_rdy  out  NBR_CHNLS  Near-side MAC ready.
- sl_tx_dcc_dll_lock_req  out  NBR_CHNLS  TX lock request.
- sl_rx_dcc_dll_lock_req  out  NBR_CHNLS  RX lock request.
- fs_mac_rdy  in  NBR_CHNLS  Far-side MAC ready.
- sl_tx_transfer_en  in  NBR_CHNLS  TX transfer enabled.
- m_rx_align_done  in  NBR_CHNLS  RX alignment done.
- link_up  out  1  High while in UP.
- link_fail  out  1  High while in FAIL.
- retry_cnt  out  2  Retries consumed; saturates at 3.
- state  out  3  Encoded FSM state, for debug.

Behaviour:
- Reset: all outputs are 0; state = IDLE; cfg index = 0; timer = 0; retry_cnt = 0.
- The active mask A has bits [ACTIVE_CHNLS-1:0] = 1. Per-channel outputs are (level & A). Per-channel inputs are evaluated as (in & A) == A.
- States and encodings: IDLE 0, CFG 1, RST_REL 2, LOCK 3, WAIT_XFER 4, UP 5, RECOVER 6, FAIL 7.
- IDLE: when start=1, go to CFG with index = 0. start is ignored in all states except IDLE and FAIL.
- CFG:
  - write = 1; addr and wdata come from table entry [index]; byte_en = all-ones.
  - Standard Avalon-MM rules: addr, wdata and write are held stable while waitreq = 1.
  - Acceptance is a cycle with write=1 and waitreq=0.
  - On acceptance with index < NUM_CFG-1: index += 1, and the next entry is presented the following cycle with no idle gap.
  - On acceptance of the last entry: write drops to 0 the next cycle; go to RST_REL.
  - waitreq may stay high indefinitely; there is no timeout in CFG.
- RST_REL:
  - ns_adapter_rstn = A and ns_mac_rdy = A, asserted on the first cycle in RST_REL.
  - Count SETTLE_CYC cycles, then go to LOCK.
- LOCK:
  - TX and RX lock requests = A, held through WAIT_XFER and UP.
  - Go to WAIT_XFER in the next cycle; timer clears to 0.
- WAIT_XFER:
  - The timer increments every cycle.
  - If fs_mac_rdy, sl_tx_transfer_en and m_rx_align_done are all complete for A in the same cycle, go to UP in the next cycle.
  - Otherwise, when timer reaches TIMEOUT_CYC-1, go to RECOVER.
  - If both conditions hit in the same cycle, success wins.
- UP: link_up = 1. If any of the three inputs becomes incomplete for A, go to RECOVER in the next cycle and link_up falls at that same transition.
- RECOVER:
  - Deassert ns_adapter_rstn, ns_mac_rdy and both lock requests for one cycle.
  - If retry_cnt < MAX_RETRY: retry_cnt += 1, then go to RST_REL. Config is not rewritten.
  - Otherwise go to FAIL.
- FAIL: link_fail = 1; all per-channel outputs are 0. On start: retry_cnt = 0, go to CFG.
- A successful UP entry does not clear retry_cnt; only rst_wr or a start from FAIL clears it.
- rst_wr mid-operation, including mid-write with waitreq=1: all outputs are 0 in the next cycle; the outstanding write is abandoned.
- Timers: timer width is $clog2(TIMEOUT_CYC+1); settle counter width is $clog2(SETTLE_CYC+1); both wrap-free.

Test Plan:
- NUM_CFG=2, entries {0x00208:0x1, 0x00210:0xA5A5}, waitreq=0, start pulse → write is high for exactly 2 consecutive cycles with addr 0x208 then 0x210; RST_REL entered on cycle 3.
- Same config, waitreq held high 5 cycles on entry 0 → addr/wdata are stable for all 6 cycles and entry 1 follows immediately after acceptance.
- ACTIVE_CHNLS=1; raise fs_mac_rdy[0], sl_tx_transfer_en[0] and m_rx_align_done[0] 10 cycles into WAIT_XFER → link_up=1 one cycle later; bits [23:1] of every per-channel output remain 0 throughout.
- TIMEOUT_CYC=32, MAX_RETRY=3, inputs never complete → 3 RECOVER passes with retry_cnt 1, 2, 3; the fourth timeout goes to FAIL with link_fail=1; a subsequent start clears retry_cnt and write is reasserted.
- In UP, drop m_rx_align_done[0] for one cycle → link_up falls, one-cycle RECOVER (ns_adapter_rstn[0]=0), RST_REL re-entered; restoring the inputs returns to UP.
- Assert rst_wr during CFG with waitreq=1 → next cycle write=0, state=IDLE, all outputs 0.

Source files
------------

// File: rtl/aib_link_bringup_ctrl_if.sv
// Avalon-MM config port between the bring-up sequencer (master) and the AIB config endpoint (slave).
// Write is held with stable address/data until a cycle with waitreq low accepts it.
interface aib_link_bringup_ctrl_if #(
   parameter int AVMM_WIDTH = 32,
   parameter int BYTE_WIDTH = 4
);
   logic [16:0]           o_cfg_avmm_addr;
   logic [BYTE_WIDTH-1:0] o_cfg_avmm_byte_en;
   logic                  o_cfg_avmm_write;
   logic [AVMM_WIDTH-1:0] o_cfg_avmm_wdata;
   logic                  i_cfg_avmm_waitreq;

   modport master (
      output o_cfg_avmm_addr, o_cfg_avmm_byte_en, o_cfg_avmm_write, o_cfg_avmm_wdata,
      input  i_cfg_avmm_waitreq
   );

   modport slave (
      input  o_cfg_avmm_addr, o_cfg_avmm_byte_en, o_cfg_avmm_write, o_cfg_avmm_wdata,
      output i_cfg_avmm_waitreq
   );
endinterface

// File: rtl/aib_link_bringup_ctrl.sv
// AIB follower bring-up: table-driven config writes, reset release, lock request, wait for link, retry/fail.
// Outputs decode the registered state (zero added latency); config writes stall indefinitely on waitreq.
module aib_link_bringup_ctrl #(
   parameter int                            NBR_CHNLS    = 24,
   parameter int                            ACTIVE_CHNLS = 1,
   parameter int                            AVMM_WIDTH   = 32,
   parameter int                            BYTE_WIDTH   = 4,
   parameter int                            NUM_CFG      = 4,
   parameter logic [NUM_CFG*17-1:0]         CFG_ADDR     = '0,
   parameter logic [NUM_CFG*AVMM_WIDTH-1:0] CFG_DATA     = '0,
   parameter int                            SETTLE_CYC   = 16,
   parameter int                            TIMEOUT_CYC  = 65535,
   parameter int                            MAX_RETRY    = 3
) (
   input  logic                   clk_wr,
   input  logic                   rst_wr,
   input  logic                   start,
   aib_link_bringup_ctrl_if.master cfg,
   output logic [NBR_CHNLS-1:0]   ns_adapter_rstn,
   output logic [NBR_CHNLS-1:0]   ns_mac_rdy,
   output logic [NBR_CHNLS-1:0]   sl_tx_dcc_dll_lock_req,
   output logic [NBR_CHNLS-1:0]   sl_rx_dcc_dll_lock_req,
   input  logic [NBR_CHNLS-1:0]   fs_mac_rdy,
   input  logic [NBR_CHNLS-1:0]   sl_tx_transfer_en,
   input  logic [NBR_CHNLS-1:0]   m_rx_align_done,
   output logic                   link_up,
   output logic                   link_fail,
   output logic [1:0]             retry_cnt,
   output logic [2:0]             state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CFG       = 3'd1,
      S_RST_REL   = 3'd2,
      S_LOCK      = 3'd3,
      S_WAIT_XFER = 3'd4,
      S_UP        = 3'd5,
      S_RECOVER   = 3'd6,
      S_FAIL      = 3'd7
   } state_t;

   localparam int                   TW          = $clog2(TIMEOUT_CYC + 1);
   localparam int                   SW          = $clog2(SETTLE_CYC + 1);
   localparam logic [NBR_CHNLS-1:0] ACT_MASK    = {NBR_CHNLS{1'b1}} >> (NBR_CHNLS - ACTIVE_CHNLS);
   localparam logic [TW-1:0]        TMO_LAST    = TW'(TIMEOUT_CYC - 1);
   localparam logic [SW-1:0]        SETTLE_LAST = SW'(SETTLE_CYC - 1);
   localparam logic [3:0]           IDX_LAST    = 4'(NUM_CFG - 1);

   state_t        r_state, w_state_nxt;
   logic [3:0]    r_idx, w_idx_nxt;
   logic [TW-1:0] r_timer, w_timer_nxt;
   logic [SW-1:0] r_settle, w_settle_nxt;
   logic [1:0]    r_retry, w_retry_nxt;
   logic          w_ready;
   logic          w_write;
   logic          w_rst_lvl;
   logic          w_lock_lvl;

   // Only the sequenced channels must all report ready; the rest are don't-care.
   assign w_ready = ((fs_mac_rdy        & ACT_MASK) == ACT_MASK) &&
                    ((sl_tx_transfer_en & ACT_MASK) == ACT_MASK) &&
                    ((m_rx_align_done   & ACT_MASK) == ACT_MASK);

   always_ff @(posedge clk_wr) begin
      if (rst_wr) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_timer  <= '0;
         r_settle <= '0;
         r_retry  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_timer  <= w_timer_nxt;
         r_settle <= w_settle_nxt;
         r_retry  <= w_retry_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_timer_nxt  = r_timer;
      w_settle_nxt = r_settle;
      w_retry_nxt  = r_retry;
      w_write      = 1'b0;
      w_rst_lvl    = 1'b0;
      w_lock_lvl   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_CFG;
               w_idx_nxt   = '0;
            end
         end
         S_CFG: begin
            w_write = 1'b1;
            if (!cfg.i_cfg_avmm_waitreq) begin
               if (r_idx == IDX_LAST) begin
                  w_state_nxt  = S_RST_REL;
                  w_settle_nxt = '0;
               end else begin
                  w_idx_nxt = r_idx + 4'd1;
               end
            end
         end
         S_RST_REL: begin
            w_rst_lvl = 1'b1;
            if (r_settle == SETTLE_LAST) w_state_nxt  = S_LOCK;
            else                         w_settle_nxt = r_settle + 1'b1;
         end
         S_LOCK: begin
            w_rst_lvl   = 1'b1;
            w_lock_lvl  = 1'b1;
            w_timer_nxt = '0;
            w_state_nxt = S_WAIT_XFER;
         end
         S_WAIT_XFER: begin
            w_rst_lvl   = 1'b1;
            w_lock_lvl  = 1'b1;
            w_timer_nxt = r_timer + 1'b1;
            if (w_ready)                  w_state_nxt = S_UP;
            else if (r_timer == TMO_LAST) w_state_nxt = S_RECOVER;
         end
         S_UP: begin
            w_rst_lvl  = 1'b1;
            w_lock_lvl = 1'b1;
            if (!w_ready) w_state_nxt = S_RECOVER;
         end
         S_RECOVER: begin
            // Config survives a retry; only the adapter side is cycled.
            if (int'(r_retry) < MAX_RETRY) begin
               w_retry_nxt  = (r_retry == 2'd3) ? 2'd3 : r_retry + 2'd1;
               w_settle_nxt = '0;
               w_state_nxt  = S_RST_REL;
            end else begin
               w_state_nxt = S_FAIL;
            end
         end
         S_FAIL: begin
            if (start) begin
               w_retry_nxt = '0;
               w_idx_nxt   = '0;
               w_state_nxt = S_CFG;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign cfg.o_cfg_avmm_write   = w_write;
   assign cfg.o_cfg_avmm_byte_en = w_write ? {BYTE_WIDTH{1'b1}} : '0;
   assign cfg.o_cfg_avmm_addr    = w_write ? CFG_ADDR[17*r_idx +: 17] : '0;
   assign cfg.o_cfg_avmm_wdata   = w_write ? CFG_DATA[AVMM_WIDTH*r_idx +: AVMM_WIDTH] : '0;

   assign ns_adapter_rstn        = w_rst_lvl  ? ACT_MASK : '0;
   assign ns_mac_rdy             = w_rst_lvl  ? ACT_MASK : '0;
   assign sl_tx_dcc_dll_lock_req = w_lock_lvl ? ACT_MASK : '0;
   assign sl_rx_dcc_dll_lock_req = w_lock_lvl ? ACT_MASK : '0;

   assign link_up   = (r_state == S_UP);
   assign link_fail = (r_state == S_FAIL);
   assign retry_cnt = r_retry;
   assign state     = r_state;

endmodule

// File: tb/tb_aib_link_bringup_ctrl.sv
`timescale 1ns/1ps
module tb_aib_link_bringup_ctrl;
   localparam int NCH = 24, ACT = 1, AW = 32, BW = 4, NCFG = 2;
   localparam int SETTLE = 4, TMO = 32, MAXR = 3;
   localparam logic [NCFG*17-1:0] CADDR = {17'h00210, 17'h00208};
   localparam logic [NCFG*AW-1:0] CDATA = {32'h0000A5A5, 32'h00000001};
   localparam logic [NCH-1:0]     AMASK = 24'h000001;

   localparam int P_IDLE = 0, P_CFG = 1, P_RST = 2, P_LOCK = 3;
   localparam int P_WAIT = 4, P_UP = 5, P_REC = 6, P_FAIL = 7;

   logic           clk_wr, rst_wr, start;
   logic [NCH-1:0] ns_adapter_rstn, ns_mac_rdy, sl_tx_dcc_dll_lock_req, sl_rx_dcc_dll_lock_req;
   logic [NCH-1:0] fs_mac_rdy, sl_tx_transfer_en, m_rx_align_done;
   logic           link_up, link_fail;
   logic [1:0]     retry_cnt;
   logic [2:0]     state;

   aib_link_bringup_ctrl_if #(.AVMM_WIDTH(AW), .BYTE_WIDTH(BW)) cfg_if ();

   aib_link_bringup_ctrl #(
      .NBR_CHNLS(NCH), .ACTIVE_CHNLS(ACT), .AVMM_WIDTH(AW), .BYTE_WIDTH(BW),
      .NUM_CFG(NCFG), .CFG_ADDR(CADDR), .CFG_DATA(CDATA),
      .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR)
   ) dut (
      .clk_wr(clk_wr), .rst_wr(rst_wr), .start(start), .cfg(cfg_if),
      .ns_adapter_rstn(ns_adapter_rstn), .ns_mac_rdy(ns_mac_rdy),
      .sl_tx_dcc_dll_lock_req(sl_tx_dcc_dll_lock_req), .sl_rx_dcc_dll_lock_req(sl_rx_dcc_dll_lock_req),
      .fs_mac_rdy(fs_mac_rdy), .sl_tx_transfer_en(sl_tx_transfer_en), .m_rx_align_done(m_rx_align_done),
      .link_up(link_up), .link_fail(link_fail), .retry_cnt(retry_cnt), .state(state)
   );

   initial clk_wr = 1'b0;
   always #5 clk_wr = ~clk_wr;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: current phase, cycles spent in it, config entry, retries used.
   int m_ph = P_IDLE, m_dwell = 0, m_idx = 0, m_retry = 0;
   logic [16:0] m_addr [NCFG];
   logic [31:0] m_data [NCFG];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic all_active(input logic [NCH-1:0] v);
      for (int i = 0; i < ACT; i++) if (!v[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge();
      logic rdy;
      rdy = all_active(fs_mac_rdy) && all_active(sl_tx_transfer_en) && all_active(m_rx_align_done);
      if (rst_wr) begin
         m_ph = P_IDLE; m_dwell = 0; m_idx = 0; m_retry = 0;
      end else begin
         case (m_ph)
            P_IDLE: if (start) begin m_ph = P_CFG; m_idx = 0; end
            P_CFG: if (!cfg_if.i_cfg_avmm_waitreq) begin
               if (m_idx == NCFG - 1) begin m_ph = P_RST; m_dwell = 0; end
               else m_idx++;
            end
            P_RST: begin m_dwell++; if (m_dwell == SETTLE) m_ph = P_LOCK; end
            P_LOCK: begin m_ph = P_WAIT; m_dwell = 0; end
            P_WAIT: begin
               m_dwell++;
               if (rdy) m_ph = P_UP;
               else if (m_dwell == TMO) m_ph = P_REC;
            end
            P_UP: if (!rdy) m_ph = P_REC;
            P_REC: if (m_retry < MAXR) begin
               m_retry = (m_retry >= 3) ? 3 : m_retry + 1;
               m_ph = P_RST; m_dwell = 0;
            end else m_ph = P_FAIL;
            default: if (start) begin m_retry = 0; m_idx = 0; m_ph = P_CFG; end
         endcase
      end
   endtask

   function automatic logic [255:0] model_vec();
      logic w;
      logic [NCH-1:0] rl, ll;
      w  = (m_ph == P_CFG);
      rl = (m_ph inside {P_RST, P_LOCK, P_WAIT, P_UP}) ? AMASK : '0;
      ll = (m_ph inside {P_LOCK, P_WAIT, P_UP}) ? AMASK : '0;
      return {99'b0, 3'(m_ph), 2'(m_retry), (m_ph == P_FAIL), (m_ph == P_UP), ll, ll, rl, rl,
              w, (w ? 4'hF : 4'h0), (w ? m_addr[m_idx] : 17'h0), (w ? m_data[m_idx] : 32'h0)};
   endfunction

   function automatic logic [255:0] dut_vec();
      return {99'b0, state, retry_cnt, link_fail, link_up, sl_rx_dcc_dll_lock_req, sl_tx_dcc_dll_lock_req,
              ns_mac_rdy, ns_adapter_rstn, cfg_if.o_cfg_avmm_write, cfg_if.o_cfg_avmm_byte_en,
              cfg_if.o_cfg_avmm_addr, cfg_if.o_cfg_avmm_wdata};
   endfunction

   task automatic step(input string tag);
      @(posedge clk_wr);
      model_edge();
      #1;
      check({"model ", tag}, dut_vec(), model_vec());
   endtask

   // Inactive channel bits get random junk so masking is exercised.
   task automatic set_in(input logic rst, input logic st, input logic wr,
                         input logic f, input logic t, input logic r);
      rst_wr = rst;
      start  = st;
      cfg_if.i_cfg_avmm_waitreq = wr;
      fs_mac_rdy        = (NCH'($urandom) & ~AMASK) | (f ? AMASK : '0);
      sl_tx_transfer_en = (NCH'($urandom) & ~AMASK) | (t ? AMASK : '0);
      m_rx_align_done   = (NCH'($urandom) & ~AMASK) | (r ? AMASK : '0);
   endtask

   task automatic wait_state(input logic [2:0] tgt, input int budget, input string name);
      int k;
      k = 0;
      while (state !== tgt && k < budget) begin
         step(name);
         k++;
      end
      check({name, " reached"}, 256'(state), 256'(tgt));
   endtask

   typedef struct packed {
      logic       rst, st, wr;
      logic [2:0] s;
      logic [1:0] sel;   // 0: no write, 1/2: table entry presented
      logic       rn, lk, up;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic st, input logic wr, input logic [2:0] s,
                               input logic [1:0] sel, input logic rn, input logic lk, input logic up);
      vec_t v;
      v.rst = rst; v.st = st; v.wr = wr; v.s = s; v.sel = sel; v.rn = rn; v.lk = lk; v.up = up;
      return v;
   endfunction

   function automatic logic [255:0] row_exp(input vec_t v);
      logic [16:0] a;
      logic [31:0] d;
      a = (v.sel == 2'd1) ? 17'h00208 : (v.sel == 2'd2) ? 17'h00210 : 17'h0;
      d = (v.sel == 2'd1) ? 32'h1 : (v.sel == 2'd2) ? 32'hA5A5 : 32'h0;
      return 256'({v.s, (v.sel != 2'd0), a, d, v.rn, v.lk, v.up});
   endfunction

   function automatic logic [255:0] row_act();
      return 256'({state, cfg_if.o_cfg_avmm_write, cfg_if.o_cfg_avmm_addr, cfg_if.o_cfg_avmm_wdata,
                   ns_adapter_rstn[0], sl_rx_dcc_dll_lock_req[0], link_up});
   endfunction

   initial begin
      vec_t tv[$];
      int wait_run, n_waits, bad_wait, n_seen, prev;
      logic [5:0] seen;
      logic healthy;

      m_addr[0] = 17'h00208; m_addr[1] = 17'h00210;
      m_data[0] = 32'h1;     m_data[1] = 32'hA5A5;

      // Reset, unstalled 2-entry write, ignored start, reset from RST_REL and mid-write, stalled entry 0.
      tv.push_back(mk(1,0,0, 3'd0, 0, 0,0,0));
      tv.push_back(mk(0,0,0, 3'd0, 0, 0,0,0));
      tv.push_back(mk(0,1,0, 3'd1, 1, 0,0,0));
      tv.push_back(mk(0,0,0, 3'd1, 2, 0,0,0));
      tv.push_back(mk(0,0,0, 3'd2, 0, 1,0,0));
      tv.push_back(mk(0,1,0, 3'd2, 0, 1,0,0));
      tv.push_back(mk(0,0,0, 3'd2, 0, 1,0,0));
      tv.push_back(mk(1,0,0, 3'd0, 0, 0,0,0));
      tv.push_back(mk(0,1,0, 3'd1, 1, 0,0,0));
      tv.push_back(mk(0,0,1, 3'd1, 1, 0,0,0));
      tv.push_back(mk(1,0,1, 3'd0, 0, 0,0,0));
      tv.push_back(mk(0,1,1, 3'd1, 1, 0,0,0));
      for (int i = 0; i < 5; i++) tv.push_back(mk(0,0,1, 3'd1, 1, 0,0,0));
      tv.push_back(mk(0,0,0, 3'd1, 2, 0,0,0));
      tv.push_back(mk(0,0,0, 3'd2, 0, 1,0,0));
      for (int i = 0; i < 3; i++) tv.push_back(mk(0,0,0, 3'd2, 0, 1,0,0));
      tv.push_back(mk(0,0,0, 3'd3, 0, 1,1,0));
      tv.push_back(mk(0,0,0, 3'd4, 0, 1,1,0));

      set_in(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < tv.size(); i++) begin
         set_in(tv[i].rst, tv[i].st, tv[i].wr, 0, 0, 0);
         step($sformatf("row%0d", i));
         check($sformatf("vec row%0d", i), row_act(), row_exp(tv[i]));
      end

      // Inputs complete 10 cycles into WAIT_XFER.
      set_in(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) step("wait10");
      check("still waiting", 256'(state), 256'(3'd4));
      set_in(0, 0, 0, 1, 1, 1);
      step("up");
      check("link_up", 256'({state, link_up, retry_cnt}), 256'({3'd5, 1'b1, 2'd0}));
      check("up masks", 256'({ns_adapter_rstn, ns_mac_rdy, sl_tx_dcc_dll_lock_req, sl_rx_dcc_dll_lock_req}),
            256'({4{24'h000001}}));
      set_in(0, 0, 0, 1, 1, 1);
      step("up hold");

      // One-cycle align drop from UP.
      set_in(0, 0, 0, 1, 1, 0);
      step("drop");
      check("recover", 256'({state, link_up, ns_adapter_rstn, retry_cnt}), 256'({3'd6, 1'b0, 24'h0, 2'd0}));
      set_in(0, 0, 0, 1, 1, 1);
      step("rerel");
      check("rst_rel again", 256'({state, ns_adapter_rstn, retry_cnt}), 256'({3'd2, 24'h000001, 2'd1}));
      wait_state(3'd5, 20, "reup");
      check("retry kept", 256'(retry_cnt), 256'(2'd1));

      // Repeated timeouts to FAIL, then restart.
      set_in(1, 0, 0, 0, 0, 0); step("rstC");
      set_in(0, 1, 0, 0, 0, 0); step("startC");
      set_in(0, 0, 0, 0, 0, 0);
      wait_run = 0; n_waits = 0; bad_wait = 0; n_seen = 0; seen = '0; prev = int'(state);
      for (int i = 0; i < 400 && state !== 3'd7; i++) begin
         step("tmo");
         if (state == 3'd4) wait_run++;
         else begin
            if (wait_run != 0) begin
               n_waits++;
               if (wait_run != TMO) bad_wait++;
            end
            wait_run = 0;
         end
         if (prev == P_REC && state == 3'd2) begin
            n_seen++;
            seen = {seen[3:0], retry_cnt};
         end
         prev = int'(state);
         set_in(0, 0, 0, 0, 0, 0);
      end
      check("fail state", 256'({state, link_fail, link_up, ns_adapter_rstn, sl_tx_dcc_dll_lock_req}),
            256'({3'd7, 1'b1, 1'b0, 24'h0, 24'h0}));
      check("retry seq", 256'({n_seen, seen, retry_cnt}), 256'({32'd3, 6'b01_10_11, 2'd3}));
      check("wait lengths", 256'({n_waits, bad_wait}), 256'({32'd4, 32'd0}));
      set_in(0, 1, 0, 0, 0, 0);
      step("restart");
      check("restart", 256'({state, retry_cnt, cfg_if.o_cfg_avmm_write, cfg_if.o_cfg_avmm_addr}),
            256'({3'd1, 2'd0, 1'b1, 17'h00208}));

      // Randomized traffic against the model.
      healthy = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         logic f, t, r;
         if ($urandom_range(0, 39) == 0) healthy = !healthy;
         f = healthy || ($urandom_range(0, 1) == 1);
         t = healthy || ($urandom_range(0, 1) == 1);
         r = healthy || ($urandom_range(0, 1) == 1);
         set_in($urandom_range(0, 599) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 2) == 0, f, t, r);
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
